register_file_mp: RTL

- Multi-port, parametrised general-purpose register file with an integrated pending-write scoreboard for the hardware-scheduled pipeline.
- Provides NUM_READ combinational read ports and NUM_WRITE synchronous write ports.
- Register 0 is hardwired to zero.
- The scoreboard tracks registers with an in-flight producer so the hazard unit can stall or forward without a separate table.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/decoder_N.sv | 16 +
 rtl/regfile_read_port.sv | 46 ++++
 rtl/register_file_mp.sv | 91 +++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Optional write-to-read bypass is enabled by REGFILE_WRITE_BYPASS_EN.
package regfile_pkg;

  localparam int REG_ZERO = 0;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_NUM_READ = 2;
  localparam int DEF_NUM_WRITE = 2;

  function automatic int addr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decoder_N.sv
// Enabled N-bit to one-hot decoder.
module decoder_N #(
  parameter int N = 5,
  localparam int M = 1 << N
) (
  input  logic         en_i,
  input  logic [N-1:0] sel_i,
  output logic [M-1:0] dec_o
);

  always_comb begin
    dec_o = '0;
    if (en_i) dec_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/regfile_read_port.sv
// One combinational read port: data mux, pending lookup, zero forcing.
// REGFILE_WRITE_BYPASS_EN adds same-cycle forwarding from write ports.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGISTERS = DEF_NUM_REGS,
  parameter int NUM_WRITE = DEF_NUM_WRITE,
  localparam int AW = addr_width(NUM_REGISTERS)
) (
  input  logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [NUM_REGISTERS-1:0]                 busy_i,
  input  logic [AW-1:0]                            ra_i,
  input  logic [NUM_WRITE-1:0]                     we_i,
  input  logic [NUM_WRITE*AW-1:0]                  wa_i,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]          wd_i,
  output logic [DATA_WIDTH-1:0]                    rd_o,
  output logic                                     pending_o
);

  logic is_zero;
  assign is_zero = (ra_i == AW'(REG_ZERO));

`ifdef REGFILE_WRITE_BYPASS_EN
  always_comb begin
    rd_o = is_zero ? '0 : regs_i[ra_i];
    pending_o = is_zero ? 1'b0 : busy_i[ra_i];
    // Later ports override earlier ones, matching write priority.
    for (int k = 0; k < NUM_WRITE; k++) begin
      if (we_i[k] && !is_zero && wa_i[k*AW +: AW] == ra_i) begin
        rd_o = wd_i[k*DATA_WIDTH +: DATA_WIDTH];
        pending_o = 1'b0;
      end
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{we_i, wa_i, wd_i};

  always_comb begin
    rd_o = is_zero ? '0 : regs_i[ra_i];
    pending_o = is_zero ? 1'b0 : busy_i[ra_i];
  end
`endif

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with pending-write scoreboard.
// Optional same-cycle bypass: define REGFILE_WRITE_BYPASS_EN.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REGISTERS = DEF_NUM_REGS,
  parameter int NUM_READ = DEF_NUM_READ,
  parameter int NUM_WRITE = DEF_NUM_WRITE,
  localparam int AW = addr_width(NUM_REGISTERS)
) (
  input  logic                            i_CLK,
  input  logic                            i_RST,
  input  logic [NUM_WRITE-1:0]            i_WE,
  input  logic [NUM_WRITE*AW-1:0]         i_WA,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] i_WD,
  input  logic [NUM_READ*AW-1:0]          i_RA,
  output logic [NUM_READ*DATA_WIDTH-1:0]  o_RD,
  input  logic                            i_ISSUE,
  input  logic [AW-1:0]                   i_ISSUE_RD,
  output logic [NUM_READ-1:0]             o_RA_PENDING,
  output logic [NUM_REGISTERS-1:0]        o_BUSY
);

  logic [NUM_WRITE-1:0][NUM_REGISTERS-1:0] wdec;
  logic [NUM_REGISTERS-1:0] idec;
  logic [NUM_REGISTERS-1:0] wr_hit;
  logic [NUM_REGISTERS-1:0] busy_d, busy_q;
  logic [NUM_REGISTERS-1:0][DATA_WIDTH-1:0] regs_d, regs_q;

  for (genvar k = 0; k < NUM_WRITE; k++) begin : g_wdec
    decoder_N #(.N(AW)) u_wdec (
      .en_i (i_WE[k]),
      .sel_i(i_WA[k*AW +: AW]),
      .dec_o(wdec[k])
    );
  end

  decoder_N #(.N(AW)) u_idec (
    .en_i (i_ISSUE),
    .sel_i(i_ISSUE_RD),
    .dec_o(idec)
  );

  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int k = 0; k < NUM_WRITE; k++) begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
        if (wdec[k][r]) begin
          regs_d[r] = i_WD[k*DATA_WIDTH +: DATA_WIDTH];
          wr_hit[r] = 1'b1;
        end
      end
    end
    // A same-cycle issue is a newer producer, so set beats clear.
    busy_d = (busy_q & ~wr_hit) | idec;
    regs_d[REG_ZERO] = '0;
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign o_BUSY = busy_q;

  for (genvar j = 0; j < NUM_READ; j++) begin : g_rd
    regfile_read_port #(
      .DATA_WIDTH   (DATA_WIDTH),
      .NUM_REGISTERS(NUM_REGISTERS),
      .NUM_WRITE    (NUM_WRITE)
    ) u_rp (
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .ra_i     (i_RA[j*AW +: AW]),
      .we_i     (i_WE),
      .wa_i     (i_WA),
      .wd_i     (i_WD),
      .rd_o     (o_RD[j*DATA_WIDTH +: DATA_WIDTH]),
      .pending_o(o_RA_PENDING[j])
    );
  end

endmodule
